byte_serial_add_ctrl: RTL and testbench

Sequencer that performs a 32-bit add or subtract by time-multiplexing one external 8-bit ripple adder slice over four cycles, least-significant byte first. It latches operands through a valid/ready request port, drives the slice's operand and carry-in inputs each cycle, and collects the sum bytes and the inter-byte carry. The result, carry-out and signed-overflow flags are held on a valid/ready result port. It sits between the ALU control and a shared 8-bit adder slice in area-reduced ALU builds.

---
 rtl/byte_serial_add_ctrl.sv | 109 ++++++++++
 tb/tb_byte_serial_add_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/byte_serial_add_ctrl.sv
// Byte-serial 32-bit add/subtract sequencer driving a shared external 8-bit adder slice.
// Four steps LSB first, registered inter-byte carry, result held on a valid/ready port.
module byte_serial_add_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        op_sub,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [7:0]  slice_a,
  output logic [7:0]  slice_b,
  output logic        slice_cin,
  input  logic [7:0]  slice_s,
  input  logic        slice_cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        carry_out,
  output logic        overflow,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // valid is never withdrawn by the producer and ready does not depend on valid.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [1:0]  idx;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic        sub_r;
  logic        carry_r;
  logic [31:0] res_r;
  logic        cout_r;
  logic        ovf_r;

  logic        accept;
  logic        run_last;

  assign accept   = (state == IDLE) && in_valid;
  assign run_last = (state == RUN) && (idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= 2'd0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      sub_r   <= 1'b0;
      carry_r <= 1'b0;
      res_r   <= 32'd0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r     <= op_a;
            // B is stored pre-inverted for subtract; the +1 enters as the step-0 carry-in.
            b_r     <= op_sub ? ~op_b : op_b;
            sub_r   <= op_sub;
            carry_r <= 1'b0;
            res_r   <= 32'd0;
            idx     <= 2'd0;
            state   <= RUN;
          end
        end
        RUN: begin
          res_r[{idx, 3'b000} +: 8] <= slice_s;
          carry_r <= slice_cout;
          idx     <= idx + 2'd1;
          if (run_last) begin
            cout_r <= slice_cout;
            ovf_r  <= (a_r[31] == b_r[31]) && (slice_s[7] != a_r[31]);
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    slice_a   = 8'd0;
    slice_b   = 8'd0;
    slice_cin = 1'b0;
    if (state == RUN) begin
      slice_a   = a_r[{idx, 3'b000} +: 8];
      slice_b   = b_r[{idx, 3'b000} +: 8];
      slice_cin = (idx == 2'd0) ? sub_r : carry_r;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = res_r;
  assign carry_out = cout_r;
  assign overflow  = ovf_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// Directed and random bench for byte_serial_add_ctrl with a behavioural 8-bit adder slice.
module tb_byte_serial_add_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        op_sub;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [7:0]  slice_a;
  logic [7:0]  slice_b;
  logic        slice_cin;
  logic [7:0]  slice_s;
  logic        slice_cout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        carry_out;
  logic        overflow;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int n_accept = 0;
  int n_result = 0;
  logic [33:0] exp_q[$];

  byte_serial_add_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .op_a(op_a), .op_b(op_b),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_s(slice_s), .slice_cout(slice_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .overflow(overflow),
    .dbg_state(dbg_state)
  );

  // external shared adder slice
  assign {slice_cout, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {8'd0, slice_cin};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic sub);
    logic [31:0] bb;
    logic [32:0] s;
    bb = sub ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {32'd0, sub};
    return {s[32], (a[31] == bb[31]) && (s[31] != a[31]), s[31:0]};
  endfunction

  // drive a request (at a negedge) and return after the accepting posedge
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub);
    int n;
    @(negedge clk);
    op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n < 50), 32'd1);
    @(posedge clk);
    n_accept++;
    exp_q.push_back(ref_model(a, b, sub));
    #1 in_valid = 1'b0;
  endtask

  // call right after send: wait for out_valid at negedges, return latency count
  task automatic wait_valid(output int n);
    @(negedge clk);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic consume(input string tag);
    logic [33:0] e;
    e = exp_q.pop_front();
    check({tag, "_result"}, result, e[31:0]);
    check({tag, "_cout"}, 32'(carry_out), 32'(e[33]));
    check({tag, "_ovf"}, 32'(overflow), 32'(e[32]));
    out_ready = 1'b1;
    @(posedge clk);
    n_result++;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic [31:0] er, input logic ec, input logic ev);
    int n;
    logic [33:0] m;
    send(a, b, sub);
    // hand-computed constant overrides the model entry so both are exercised
    m = exp_q.pop_back();
    check({tag, "_model"}, m[31:0], er);
    exp_q.push_back({ec, ev, er});
    wait_valid(n);
    check({tag, "_latency"}, n, 4);
    consume(tag);
  endtask

  initial begin
    int n;
    logic [31:0] held;
    rst_n = 1'b0; in_valid = 1'b0; op_sub = 1'b0; op_a = '0; op_b = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_slice", {15'd0, slice_cin, slice_a, slice_b}, 32'd0);
    rst_n = 1'b1;

    // 0xFF + 1 with per-step slice observation
    send(32'h000000FF, 32'h00000001, 1'b0);
    @(negedge clk);
    check("s0_a", 32'(slice_a), 32'hFF);
    check("s0_b", 32'(slice_b), 32'h01);
    check("s0_cin", 32'(slice_cin), 32'd0);
    @(negedge clk);
    check("s1_cin", 32'(slice_cin), 32'd1);
    @(negedge clk);
    check("s2_cin", 32'(slice_cin), 32'd0);
    @(negedge clk);
    check("s3_cin", 32'(slice_cin), 32'd0);
    check("s3_not_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("ff1_valid", 32'(out_valid), 32'd1);
    check("idle_slice", {15'd0, slice_cin, slice_a, slice_b}, 32'd0);
    check("ff1_hand", result, 32'h00000100);
    consume("ff1");

    do_op("wrap",   32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
    do_op("posovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
    do_op("sub57",  32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    do_op("subovf", 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);

    // stall with a pending request
    send(32'h00000010, 32'h00000020, 1'b0);
    wait_valid(n);
    check("stall_latency", n, 4);
    op_a = 32'h0000AAAA; op_b = 32'h00005555; op_sub = 1'b0; in_valid = 1'b1;
    held = result;
    check("stall_first", held, 32'h00000030);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_result", result, held);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_valid", 32'(out_valid), 32'd1);
    end
    consume("stall");
    @(posedge clk);
    n_accept++;
    exp_q.push_back(ref_model(32'h0000AAAA, 32'h00005555, 1'b0));
    #1 in_valid = 1'b0;
    check("second_accept", 32'(dbg_state), 32'd1);
    wait_valid(n);
    check("second_latency", n, 4);
    check("second_hand", result, 32'h0000FFFF);
    consume("second");

    // asynchronous reset during step 2
    send(32'h12345678, 32'h11111111, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_flags", {30'd0, carry_out, overflow}, 32'd0);
    check("arst_slice", {15'd0, slice_cin, slice_a, slice_b}, 32'd0);
    void'(exp_q.pop_back());
    n_accept--;
    @(negedge clk);
    rst_n = 1'b1;
    do_op("after_rst", 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0);

    // random ops with random consumer stalls
    for (int k = 0; k < 1000; k++) begin
      logic [33:0] e;
      int stall;
      send($urandom, $urandom, 1'($urandom_range(0, 1)));
      out_ready = 1'($urandom_range(0, 1));
      wait_valid(n);
      check("rnd_latency", n, 4);
      stall = out_ready ? 0 : $urandom_range(0, 3);
      repeat (stall) @(negedge clk);
      e = exp_q.pop_front();
      check("rnd_result", result, e[31:0]);
      check("rnd_flags", {30'd0, carry_out, overflow}, {30'd0, e[33:32]});
      out_ready = 1'b1;
      @(posedge clk);
      n_result++;
      @(negedge clk);
      out_ready = 1'b0;
      check("rnd_one_result", 32'(out_valid), 32'd0);
    end
    check("q_empty", exp_q.size(), 0);
    check("accept_vs_result", n_accept, n_result);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
